// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives IMEM and pairs returned words with their PC.
// Define FETCH_PERF_COUNTERS_EN to build the perf_fetched/perf_stalls counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] IMEM_SIZE = 32'h8000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        fetch_fault,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalls
);

  localparam logic [31:0] LAST_ADDR = IMEM_SIZE - 32'd4;

  logic [31:0] pc_q, pc_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        out_valid_q, out_valid_d;
  logic        fault_q, fault_d;

  logic [31:0] fetch_addr, cand;
  logic        go, stall;
  logic        unused_tgt_lsbs;

  assign unused_tgt_lsbs = ^redirect_target[1:0];
  assign stall = out_valid_q & ~id_ready;

  always_comb begin
    pc_d        = pc_q;
    out_pc_d    = out_pc_q;
    out_valid_d = out_valid_q;
    fault_d     = fault_q;
    fetch_addr  = out_pc_q;   // re-read the current word unless a new fetch is issued
    cand        = pc_q;
    go          = 1'b0;
    if (!fault_q) begin
      if (redirect_valid) begin
        cand = {redirect_target[31:2], 2'b00};
        go   = 1'b1;
      end else if (!stall) begin
        if (halt) out_valid_d = 1'b0;
        else      go = 1'b1;
      end
      if (go) begin
        // An out-of-range fetch is never presented; IMEM keeps seeing the last legal word.
        if (cand > LAST_ADDR) begin
          fault_d     = 1'b1;
          out_valid_d = 1'b0;
        end else begin
          fetch_addr  = cand;
          out_pc_d    = cand;
          out_valid_d = 1'b1;
          pc_d        = cand + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      out_pc_q    <= RESET_PC;
      out_valid_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      out_pc_q    <= out_pc_d;
      out_valid_q <= out_valid_d;
      fault_q     <= fault_d;
    end
  end

  assign imem_address = rst_n ? fetch_addr : RESET_PC;
  assign out_valid    = out_valid_q;
  assign out_instr    = imem_instruction;
  assign out_pc       = out_pc_q;
  assign out_pc_plus4 = out_pc_q + 32'd4;
  assign fetch_fault  = fault_q;

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] stalls_q, stalls_d;

  always_comb begin
    fetched_d = fetched_q;
    stalls_d  = stalls_q;
    // A word accepted alongside a redirect is squashed downstream, so it is not counted.
    if (out_valid_q & id_ready & ~redirect_valid) fetched_d = fetched_q + 32'd1;
    if (stall) stalls_d = stalls_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= 32'h0;
      stalls_q  <= 32'h0;
    end else begin
      fetched_q <= fetched_d;
      stalls_q  <= stalls_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stalls  = stalls_q;
`else
  assign perf_fetched = 32'h0;
  assign perf_stalls  = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a word-level model of the fetch rules.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0;
  localparam logic [31:0] ISIZE  = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction = 32'h0;
  logic        id_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        halt = 1'b0;
  logic        out_valid;
  logic [31:0] out_instr, out_pc, out_pc_plus4;
  logic        fetch_fault;
  logic [31:0] perf_fetched, perf_stalls;

  fetch_unit #(.RESET_PC(RST_PC), .IMEM_SIZE(ISIZE)) dut (
    .clk(clk), .rst_n(rst_n), .imem_address(imem_address), .imem_instruction(imem_instruction),
    .id_ready(id_ready), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halt(halt), .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_pc_plus4(out_pc_plus4), .fetch_fault(fetch_fault),
    .perf_fetched(perf_fetched), .perf_stalls(perf_stalls)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  always @(posedge clk) imem_instruction <= mem[imem_address[7:2]];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: the word on the outputs (m_opc/m_ov), the next sequential address, fault and counters.
  logic [31:0] m_pc, m_opc, m_fet, m_stl;
  logic        m_ov, m_flt;

  task automatic model_reset();
    m_pc = RST_PC; m_opc = RST_PC; m_ov = 1'b0; m_flt = 1'b0; m_fet = 0; m_stl = 0;
  endtask

  task automatic check_outputs(input logic [31:0] exp_addr);
    chk("imem_address", imem_address, exp_addr);
    chk("out_valid", {31'h0, out_valid}, {31'h0, m_ov});
    chk("out_pc", out_pc, m_opc);
    chk("out_pc_plus4", out_pc_plus4, m_opc + 32'd4);
    chk("fetch_fault", {31'h0, fetch_fault}, {31'h0, m_flt});
    if (m_ov) chk("out_instr", out_instr, mem[m_opc[7:2]]);
`ifdef FETCH_PERF_COUNTERS_EN
    chk("perf_fetched", perf_fetched, m_fet);
    chk("perf_stalls", perf_stalls, m_stl);
`else
    chk("perf_fetched", perf_fetched, 32'h0);
    chk("perf_stalls", perf_stalls, 32'h0);
`endif
  endtask

  // Called at a negedge: apply inputs, check, advance the model across the next posedge.
  task automatic cycle(input logic rdy, input logic rv, input logic [31:0] tgt, input logic hlt);
    logic        want;
    logic        legal;
    logic [31:0] a;
    id_ready = rdy; redirect_valid = rv; redirect_target = tgt; halt = hlt;
    #1;
    want = 1'b0;
    a = m_pc;
    if (m_flt)             want = 1'b0;
    else if (rv)           begin want = 1'b1; a = tgt & ~32'h3; end
    else if (m_ov && !rdy) want = 1'b0;
    else if (hlt)          want = 1'b0;
    else                   want = 1'b1;
    legal = want && ((a >> 2) < (ISIZE >> 2));
    check_outputs(legal ? a : m_opc);
    if (m_ov && rdy && !rv) m_fet = m_fet + 1;
    if (m_ov && !rdy)       m_stl = m_stl + 1;
    if (want) begin
      if (legal) begin m_opc = a; m_ov = 1'b1; m_pc = a + 4; end
      else       begin m_flt = 1'b1; m_ov = 1'b0; end
    end else if (!m_flt && !(m_ov && !rdy) && hlt) begin
      m_ov = 1'b0;
    end
    @(negedge clk);
  endtask

  // Asserted between edges so the outputs must change with no clock.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(RST_PC);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    model_reset();
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h103, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'hE0, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
            32'($urandom_range(0, 32'h10F)), $urandom_range(0, 9) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
